// File: rtl/clk_div_pkg.sv
// Shared constants and types for the multi-channel clock divider.
// Optional feature macro: CLK_DIV_MULTI_TICK_EN (per-channel toggle strobe).
package clk_div_pkg;

  localparam int CNT_W_DEF       = 25;
  localparam int DEFAULT_DIV_DEF = 12500;
  localparam int DIV_HALT        = 0;

  typedef logic [CNT_W_DEF-1:0] div_word_t;

  // Width of the channel-select field; never narrower than one bit.
  function automatic int ch_sel_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: up-counter, active/pending divisor registers, toggle and tick.
// Tick flops exist only when CLK_DIV_MULTI_TICK_EN is defined.
module clk_div_chan
  import clk_div_pkg::*;
#(
  parameter int               CNT_W   = CNT_W_DEF,
  parameter logic [CNT_W-1:0] RST_DIV = CNT_W'(DEFAULT_DIV_DEF)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_div,
  output logic             clk_out,
  output logic             pending,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pdiv_q, pdiv_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             halted_s;
  logic             tc_s;
  logic [CNT_W-1:0] next_div_s;

  // A same-cycle write takes priority over an older pending value at apply time.
  always_comb begin
    halted_s   = (div_q == CNT_W'(DIV_HALT));
    tc_s       = 1'b0;
    next_div_s = div_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    pdiv_d     = pdiv_q;
    pend_d     = pend_q;
    clk_d      = clk_q;

    if (!halted_s && en) begin
      tc_s = (cnt_q == (div_q - CNT_W'(1)));
    end else begin
      tc_s = 1'b0;
    end

    if (wr_en) begin
      next_div_s = wr_div;
    end else if (pend_q) begin
      next_div_s = pdiv_q;
    end else begin
      next_div_s = div_q;
    end

    // Halted channels have no terminal count, so any new divisor lands immediately.
    if (halted_s) begin
      cnt_d  = CNT_W'(0);
      clk_d  = 1'b0;
      div_d  = next_div_s;
      pend_d = 1'b0;
    end else if (tc_s) begin
      cnt_d  = CNT_W'(0);
      div_d  = next_div_s;
      pend_d = 1'b0;
      if (next_div_s == CNT_W'(DIV_HALT)) begin
        clk_d = 1'b0;
      end else begin
        clk_d = ~clk_q;
      end
    end else begin
      if (en) begin
        cnt_d = cnt_q + CNT_W'(1);
      end else begin
        cnt_d = cnt_q;
      end
      if (wr_en) begin
        pdiv_d = wr_div;
        pend_d = 1'b1;
      end else begin
        pdiv_d = pdiv_q;
        pend_d = pend_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= CNT_W'(0);
      div_q  <= RST_DIV;
      pdiv_q <= CNT_W'(0);
      pend_q <= 1'b0;
      clk_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pdiv_q <= pdiv_d;
      pend_q <= pend_d;
      clk_q  <= clk_d;
    end
  end

  assign clk_out = clk_q;
  assign pending = pend_q;

`ifdef CLK_DIV_MULTI_TICK_EN
  logic tick_q, tick_d;

  // Strobe for the cycle that follows any change of the divided output.
  always_comb begin
    tick_d = (clk_d != clk_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_q <= 1'b0;
    end else begin
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;
`else
  assign tick = 1'b0;
`endif

endmodule

// File: rtl/clk_div_multi.sv
// N-channel programmable clock divider with glitch-free divisor reload.
// Define CLK_DIV_MULTI_TICK_EN to enable the per-channel tick strobes.
module clk_div_multi
  import clk_div_pkg::*;
#(
  parameter int        NUM_CH      = 4,
  parameter int        CNT_W       = CNT_W_DEF,
  parameter div_word_t DEFAULT_DIV = div_word_t'(DEFAULT_DIV_DEF)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             en,
  input  logic                          load_en,
  input  logic [ch_sel_w(NUM_CH)-1:0]   load_ch,
  input  logic [CNT_W-1:0]              load_div,
  output logic [NUM_CH-1:0]             clk_out,
  output logic [NUM_CH-1:0]             pending,
  output logic [NUM_CH-1:0]             tick
);

  localparam int LCH_W = ch_sel_w(NUM_CH);

  logic ch_ok_s;

  // Out-of-range channel numbers are dropped here, so no channel ever sees them.
  always_comb begin
    if (int'(load_ch) < NUM_CH) begin
      ch_ok_s = 1'b1;
    end else begin
      ch_ok_s = 1'b0;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_s;

    assign wr_s = load_en & ch_ok_s & (load_ch == LCH_W'(i));

    clk_div_chan #(
      .CNT_W   (CNT_W),
      .RST_DIV (CNT_W'(DEFAULT_DIV))
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (en[i]),
      .wr_en   (wr_s),
      .wr_div  (load_div),
      .clk_out (clk_out[i]),
      .pending (pending[i]),
      .tick    (tick[i])
    );
  end

endmodule

// File: tb/tb_clk_div_multi.sv
// Randomized self-checking bench for clk_div_multi against a countdown reference model.
module tb_clk_div_multi;

  localparam int NCH = 5;
  localparam int CW  = 8;
  localparam int DEF = 4;
  localparam int LW  = 3;

  logic            clk = 1'b0;
  logic            rst;
  logic [NCH-1:0]  en;
  logic            load_en;
  logic [LW-1:0]   load_ch;
  logic [CW-1:0]   load_div;
  logic [NCH-1:0]  clk_out;
  logic [NCH-1:0]  pending;
  logic [NCH-1:0]  tick;

  int errors = 0;
  int checks = 0;

  // Reference model: each channel counts down the cycles left in the current half-period.
  int m_div  [NCH];
  int m_rem  [NCH];
  int m_pv   [NCH];
  bit m_lvl  [NCH];
  bit m_pend [NCH];
  bit m_tick [NCH];

  clk_div_multi #(
    .NUM_CH      (NCH),
    .CNT_W       (CW),
    .DEFAULT_DIV (DEF)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .load_en  (load_en),
    .load_ch  (load_ch),
    .load_div (load_div),
    .clk_out  (clk_out),
    .pending  (pending),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NCH; c++) begin
      m_div[c]  = DEF;
      m_rem[c]  = DEF;
      m_pv[c]   = 0;
      m_lvl[c]  = 1'b0;
      m_pend[c] = 1'b0;
      m_tick[c] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      bit wr;
      int nd;
      bit old;
      wr = load_en && (int'(load_ch) == c);
      m_tick[c] = 1'b0;
      if (m_div[c] == 0) begin
        if (wr) begin
          m_div[c] = int'(load_div);
          m_rem[c] = int'(load_div);
        end
      end else if (en[c] && m_rem[c] == 1) begin
        nd = wr ? int'(load_div) : (m_pend[c] ? m_pv[c] : m_div[c]);
        m_pend[c] = 1'b0;
        old = m_lvl[c];
        m_lvl[c] = (nd == 0) ? 1'b0 : ~m_lvl[c];
        m_tick[c] = (m_lvl[c] != old);
        m_div[c] = nd;
        m_rem[c] = nd;
      end else begin
        if (en[c]) m_rem[c]--;
        if (wr) begin
          m_pend[c] = 1'b1;
          m_pv[c]   = int'(load_div);
        end
      end
    end
  endtask

  task automatic compare_all();
    logic [NCH-1:0] e_clk, e_pend, e_tick;
    for (int c = 0; c < NCH; c++) begin
      e_clk[c]  = m_lvl[c];
      e_pend[c] = m_pend[c];
`ifdef CLK_DIV_MULTI_TICK_EN
      e_tick[c] = m_tick[c];
`else
      e_tick[c] = 1'b0;
`endif
    end
    check("clk_out", 32'(clk_out), 32'(e_clk));
    check("pending", 32'(pending), 32'(e_pend));
    check("tick",    32'(tick),    32'(e_tick));
  endtask

  task automatic step();
    @(posedge clk);
    if (!rst) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic write(input int ch, input int dv);
    load_en  = 1'b1;
    load_ch  = LW'(ch);
    load_div = CW'(dv);
    step();
    load_en  = 1'b0;
  endtask

  initial begin
    int n;
    rst      = 1'b1;
    en       = '1;
    load_en  = 1'b0;
    load_ch  = '0;
    load_div = '0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_clk",  32'(clk_out), 32'h0);
    check("reset_pend", 32'(pending), 32'h0);
    check("reset_tick", 32'(tick),    32'h0);
    rst = 1'b0;

    cycles(3);
    check("pre_rise", 32'(clk_out), 32'h0);
    cycles(1);
    check("rise4", 32'(clk_out), 32'h1f);
    cycles(8);

    cycles(2);
    write(1, 2);
    check("pend1", 32'(pending[1]), 32'h1);
    cycles(12);

    write(2, 0);
    cycles(10);
    check("halt", 32'(clk_out[2]), 32'h0);
    write(2, 3);
    cycles(14);

    write(0, 1);
    cycles(8);

    write(7, 9);
    cycles(4);

    n = 0;
    while (m_rem[3] != 1 && n < 20) begin
      step();
      n++;
    end
    check("tc_wait", 32'(m_rem[3] == 1), 32'h1);
    write(3, 2);
    check("tc_pend", 32'(pending[3]), 32'h0);
    cycles(6);

    en[0] = 1'b0;
    write(0, 3);
    cycles(9);
    en[0] = 1'b1;
    cycles(10);

    cycles(2);
    #2;
    rst = 1'b1;
    #1;
    check("async_clk",  32'(clk_out), 32'h0);
    check("async_pend", 32'(pending), 32'h0);
    check("async_tick", 32'(tick),    32'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycles(10);

    for (int k = 0; k < 3000; k++) begin
      for (int c = 0; c < NCH; c++) en[c] = ($urandom_range(0, 7) != 0);
      load_en  = ($urandom_range(0, 3) == 0);
      load_ch  = LW'($urandom_range(0, 7));
      load_div = CW'($urandom_range(0, 6));
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
